// File: rtl/ir_pipeline_ctrl_if.sv
// Handshake bundle between the 5-stage core datapath and the instruction-register controller.
// The core side (master) supplies the fetched word and X-stage/multdiv status; the controller (slave) returns the IRs and stall/start flags.
interface ir_pipeline_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [31:0]      fetch_ir;
    logic             branch_taken;
    logic             md_ready;
    logic [31:0]      FD_IR;
    logic [31:0]      DX_IR;
    logic [31:0]      XM_IR;
    logic [31:0]      MW_IR;
    logic             pc_stall;
    logic             md_start;
    logic             md_error;
    logic [CNT_W-1:0] stall_count;

    modport master (
        output fetch_ir,
        output branch_taken,
        output md_ready,
        input  FD_IR,
        input  DX_IR,
        input  XM_IR,
        input  MW_IR,
        input  pc_stall,
        input  md_start,
        input  md_error,
        input  stall_count
    );

    modport slave (
        input  fetch_ir,
        input  branch_taken,
        input  md_ready,
        output FD_IR,
        output DX_IR,
        output XM_IR,
        output MW_IR,
        output pc_stall,
        output md_start,
        output md_error,
        output stall_count
    );
endinterface

// File: rtl/ir_pipeline_ctrl.sv
// Owns the FD/DX/XM/MW instruction registers and chooses advance, flush, load-use stall or
// multdiv hold each cycle, with a multdiv watchdog and a saturating stall counter.
module ir_pipeline_ctrl #(
    parameter logic [31:0] NOP        = 32'h00000000,
    parameter int          MD_TIMEOUT = 40,
    parameter int          CNT_W      = 16
) (
    input  logic               clock,
    input  logic               reset,
    ir_pipeline_ctrl_if.slave  bus
);

    localparam int              TW       = (MD_TIMEOUT > 2) ? $clog2(MD_TIMEOUT) : 1;
    localparam logic [TW-1:0]   TMO_LAST = TW'(MD_TIMEOUT - 1);

    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_LW    = 5'b01000;
    localparam logic [4:0] ALU_MUL  = 5'b00110;
    localparam logic [4:0] ALU_DIV  = 5'b00111;

    typedef enum logic {
        IDLE,
        BUSY
    } state_e;

    typedef enum logic [1:0] {
        ACT_ADVANCE,
        ACT_MD_HOLD,
        ACT_FLUSH,
        ACT_LOAD_STALL
    } action_e;

    state_e           state_q,     state_d;
    logic [TW-1:0]    tmo_q,       tmo_d;
    logic             md_error_q,  md_error_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [31:0]      fd_ir_q,     fd_ir_d;
    logic [31:0]      dx_ir_q,     dx_ir_d;
    logic [31:0]      xm_ir_q,     xm_ir_d;
    logic [31:0]      mw_ir_q,     mw_ir_d;

    action_e          action;
    logic             md_start;
    logic             pc_stall;

    logic [4:0] fd_opcode, fd_rs, fd_rt;
    logic [4:0] dx_opcode, dx_rd, dx_aluop;
    logic       is_md;
    logic       load_use;

    assign fd_opcode = fd_ir_q[31:27];
    assign fd_rs     = fd_ir_q[21:17];
    assign fd_rt     = fd_ir_q[16:12];
    assign dx_opcode = dx_ir_q[31:27];
    assign dx_rd     = dx_ir_q[26:22];
    assign dx_aluop  = dx_ir_q[6:2];

    assign is_md = (dx_opcode == OP_RTYPE) &&
                   ((dx_aluop == ALU_MUL) || (dx_aluop == ALU_DIV));

    // Only rs, and rt of R-types, are read in D; a store's data register (rd) is bypassed from M.
    assign load_use = (dx_opcode == OP_LW) && (dx_rd != 5'd0) &&
                      ((fd_rs == dx_rd) ||
                       ((fd_opcode == OP_RTYPE) && (fd_rt == dx_rd)));

    always_comb begin
        action     = ACT_ADVANCE;
        md_start   = 1'b0;
        state_d    = state_q;
        tmo_d      = tmo_q;
        md_error_d = md_error_q;

        if (state_q == BUSY) begin
            if (bus.md_ready) begin
                state_d = IDLE;
                tmo_d   = '0;
            end else if (tmo_q == TMO_LAST) begin
                state_d    = IDLE;
                tmo_d      = '0;
                md_error_d = 1'b1;
            end else begin
                action = ACT_MD_HOLD;
                tmo_d  = tmo_q + TW'(1);
            end
        end else if (is_md) begin
            action   = ACT_MD_HOLD;
            md_start = 1'b1;
            state_d  = BUSY;
            tmo_d    = '0;
        end else if (bus.branch_taken) begin
            action = ACT_FLUSH;
        end else if (load_use) begin
            action = ACT_LOAD_STALL;
        end
    end

    always_comb begin
        fd_ir_d  = bus.fetch_ir;
        dx_ir_d  = fd_ir_q;
        xm_ir_d  = dx_ir_q;
        mw_ir_d  = xm_ir_q;
        pc_stall = 1'b0;

        unique case (action)
            ACT_MD_HOLD: begin
                fd_ir_d  = fd_ir_q;
                dx_ir_d  = dx_ir_q;
                xm_ir_d  = NOP;
                pc_stall = 1'b1;
            end
            ACT_FLUSH: begin
                fd_ir_d = NOP;
                dx_ir_d = NOP;
            end
            ACT_LOAD_STALL: begin
                fd_ir_d  = fd_ir_q;
                dx_ir_d  = NOP;
                pc_stall = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (pc_stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            tmo_q       <= '0;
            md_error_q  <= 1'b0;
            stall_cnt_q <= '0;
            fd_ir_q     <= NOP;
            dx_ir_q     <= NOP;
            xm_ir_q     <= NOP;
            mw_ir_q     <= NOP;
        end else begin
            state_q     <= state_d;
            tmo_q       <= tmo_d;
            md_error_q  <= md_error_d;
            stall_cnt_q <= stall_cnt_d;
            fd_ir_q     <= fd_ir_d;
            dx_ir_q     <= dx_ir_d;
            xm_ir_q     <= xm_ir_d;
            mw_ir_q     <= mw_ir_d;
        end
    end

    assign bus.FD_IR       = fd_ir_q;
    assign bus.DX_IR       = dx_ir_q;
    assign bus.XM_IR       = xm_ir_q;
    assign bus.MW_IR       = mw_ir_q;
    assign bus.pc_stall    = pc_stall;
    assign bus.md_start    = md_start;
    assign bus.md_error    = md_error_q;
    assign bus.stall_count = stall_cnt_q;

endmodule

// File: tb/tb_ir_pipeline_ctrl.sv
// Directed bench for ir_pipeline_ctrl: normal flow, load-use, flush, mul/div hold, watchdog and reset.
module tb_ir_pipeline_ctrl;

    localparam logic [31:0] ADD  = 32'h018A1000;
    localparam logic [31:0] LW5  = 32'h41400000;
    localparam logic [31:0] LW0  = 32'h40000000;
    localparam logic [31:0] SW5  = 32'h39400000;
    localparam logic [31:0] MUL  = 32'h00C22018;
    localparam logic [31:0] IA   = 32'h08000000;
    localparam logic [31:0] IB   = 32'h10000000;
    localparam logic [31:0] IC   = 32'h0C000000;
    localparam logic [31:0] IF0  = 32'h18000000;
    localparam logic [31:0] IE   = 32'h14000000;

    logic clock;
    logic reset;
    int   checks;
    int   errors;

    ir_pipeline_ctrl_if #(.CNT_W(16)) bus ();

    ir_pipeline_ctrl #(
        .NOP        (32'h00000000),
        .MD_TIMEOUT (40),
        .CNT_W      (16)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic applyStimulus(input logic [31:0] fir, input logic br, input logic rdy);
        bus.fetch_ir     = fir;
        bus.branch_taken = br;
        bus.md_ready     = rdy;
        #1;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic checkIrs(input string tag, input logic [31:0] fd, input logic [31:0] dx,
                            input logic [31:0] xm, input logic [31:0] mw);
        checkOutput({tag, ".FD"}, bus.FD_IR, fd);
        checkOutput({tag, ".DX"}, bus.DX_IR, dx);
        checkOutput({tag, ".XM"}, bus.XM_IR, xm);
        checkOutput({tag, ".MW"}, bus.MW_IR, mw);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        applyStimulus(ADD, 1'b0, 1'b0);
        tick();
        tick();
        checkIrs("reset", 0, 0, 0, 0);
        checkOutput("reset.pc_stall", {31'd0, bus.pc_stall}, 0);
        checkOutput("reset.md_start", {31'd0, bus.md_start}, 0);
        checkOutput("reset.md_error", {31'd0, bus.md_error}, 0);
        checkOutput("reset.stall_count", {16'd0, bus.stall_count}, 0);
        reset = 1'b1;

        // Normal advance of one add through all four registers
        applyStimulus(ADD, 1'b0, 1'b0);
        checkOutput("norm.pc_stall0", {31'd0, bus.pc_stall}, 0);
        tick();
        checkIrs("norm1", ADD, 0, 0, 0);
        applyStimulus(0, 1'b0, 1'b0);
        tick();
        checkIrs("norm2", 0, ADD, 0, 0);
        checkOutput("norm.pc_stall2", {31'd0, bus.pc_stall}, 0);
        tick();
        checkIrs("norm3", 0, 0, ADD, 0);
        tick();
        checkIrs("norm4", 0, 0, 0, ADD);

        // Load-use: lw r5 then add r6,r5,r1
        applyStimulus(LW5, 1'b0, 1'b0);
        tick();
        applyStimulus(ADD, 1'b0, 1'b0);
        tick();
        checkIrs("lu.pre", ADD, LW5, 0, 0);
        applyStimulus(0, 1'b0, 1'b0);
        checkOutput("lu.pc_stall", {31'd0, bus.pc_stall}, 1);
        tick();
        checkIrs("lu.stall", ADD, 0, LW5, 0);
        checkOutput("lu.stall_count", {16'd0, bus.stall_count}, 1);
        checkOutput("lu.pc_stall_after", {31'd0, bus.pc_stall}, 0);
        tick();
        checkIrs("lu.adv", 0, ADD, 0, LW5);

        // lw with rd=0 is not a hazard
        applyStimulus(LW0, 1'b0, 1'b0);
        tick();
        applyStimulus(ADD, 1'b0, 1'b0);
        tick();
        checkOutput("lw0.DX", bus.DX_IR, LW0);
        checkOutput("lw0.pc_stall", {31'd0, bus.pc_stall}, 0);
        // sw r5 (rs=0) after lw r5 is not a hazard
        applyStimulus(LW5, 1'b0, 1'b0);
        tick();
        applyStimulus(SW5, 1'b0, 1'b0);
        tick();
        checkOutput("sw.DX", bus.DX_IR, LW5);
        checkOutput("sw.pc_stall", {31'd0, bus.pc_stall}, 0);
        applyStimulus(0, 1'b0, 1'b0);
        tick();
        checkIrs("sw.adv", 0, SW5, LW5, ADD);
        checkOutput("sw.stall_count", {16'd0, bus.stall_count}, 1);

        // Branch flush with FD=A, DX=B
        applyStimulus(IB, 1'b0, 1'b0);
        tick();
        applyStimulus(IA, 1'b0, 1'b0);
        tick();
        checkIrs("br.pre", IA, IB, 0, SW5);
        applyStimulus(IC, 1'b1, 1'b0);
        checkOutput("br.pc_stall", {31'd0, bus.pc_stall}, 0);
        tick();
        checkIrs("br.flush", 0, 0, IB, 0);

        // Flush wins over a simultaneous load-use
        applyStimulus(LW5, 1'b0, 1'b0);
        tick();
        applyStimulus(ADD, 1'b0, 1'b0);
        tick();
        applyStimulus(IC, 1'b1, 1'b0);
        checkOutput("brlu.pc_stall", {31'd0, bus.pc_stall}, 0);
        tick();
        checkIrs("brlu.flush", 0, 0, LW5, 0);
        checkOutput("brlu.stall_count", {16'd0, bus.stall_count}, 1);

        // mul with md_ready after four stall cycles
        applyStimulus(IF0, 1'b0, 1'b0);
        tick();
        applyStimulus(MUL, 1'b0, 1'b0);
        tick();
        applyStimulus(IC, 1'b0, 1'b0);
        tick();
        checkIrs("mul.pre", IC, MUL, IF0, 0);
        checkOutput("mul.md_start0", {31'd0, bus.md_start}, 1);
        checkOutput("mul.pc_stall0", {31'd0, bus.pc_stall}, 1);
        tick();
        checkIrs("mul.hold1", IC, MUL, 0, IF0);
        checkOutput("mul.md_start1", {31'd0, bus.md_start}, 0);
        checkOutput("mul.pc_stall1", {31'd0, bus.pc_stall}, 1);
        applyStimulus(IC, 1'b1, 1'b0);
        tick();
        checkIrs("mul.hold2", IC, MUL, 0, 0);
        applyStimulus(IC, 1'b0, 1'b0);
        tick();
        tick();
        checkOutput("mul.stall_count", {16'd0, bus.stall_count}, 5);
        applyStimulus(IE, 1'b0, 1'b1);
        checkOutput("mul.pc_stall_rel", {31'd0, bus.pc_stall}, 0);
        checkOutput("mul.md_start_rel", {31'd0, bus.md_start}, 0);
        tick();
        applyStimulus(IE, 1'b0, 1'b0);
        checkIrs("mul.rel", IE, IC, MUL, 0);
        checkOutput("mul.md_start_after", {31'd0, bus.md_start}, 0);
        checkOutput("mul.pc_stall_after", {31'd0, bus.pc_stall}, 0);

        // Watchdog: md_ready never arrives
        applyStimulus(MUL, 1'b0, 1'b0);
        tick();
        applyStimulus(0, 1'b0, 1'b0);
        tick();
        checkOutput("tmo.md_start", {31'd0, bus.md_start}, 1);
        for (int i = 0; i < 40; i++) begin
            checkOutput($sformatf("tmo.pc_stall%0d", i), {31'd0, bus.pc_stall}, 1);
            tick();
        end
        checkOutput("tmo.pc_stall_rel", {31'd0, bus.pc_stall}, 0);
        checkOutput("tmo.md_error_pre", {31'd0, bus.md_error}, 0);
        tick();
        checkOutput("tmo.md_error", {31'd0, bus.md_error}, 1);
        checkOutput("tmo.XM", bus.XM_IR, MUL);
        checkOutput("tmo.stall_count", {16'd0, bus.stall_count}, 45);
        tick();
        tick();
        checkOutput("tmo.md_error_sticky", {31'd0, bus.md_error}, 1);
        checkOutput("tmo.md_start_idle", {31'd0, bus.md_start}, 0);

        // Reset in the middle of BUSY
        applyStimulus(MUL, 1'b0, 1'b0);
        tick();
        applyStimulus(0, 1'b0, 1'b0);
        tick();
        checkOutput("rb.md_start", {31'd0, bus.md_start}, 1);
        tick();
        tick();
        reset = 1'b0;
        #1;
        checkIrs("rb", 0, 0, 0, 0);
        checkOutput("rb.md_error", {31'd0, bus.md_error}, 0);
        checkOutput("rb.md_start", {31'd0, bus.md_start}, 0);
        checkOutput("rb.pc_stall", {31'd0, bus.pc_stall}, 0);
        checkOutput("rb.stall_count", {16'd0, bus.stall_count}, 0);
        tick();
        reset = 1'b1;
        applyStimulus(ADD, 1'b0, 1'b0);
        tick();
        checkOutput("rb.FD", bus.FD_IR, ADD);
        checkOutput("rb.pc_stall_idle", {31'd0, bus.pc_stall}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
